// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor, one round per clock, on-the-fly key expansion.
// Define AES_ABORT_EN to add the abort input (drops any block in flight and clears all registers).

module aes_sbox (
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq, inv;

  // Multiplicative inverse as d^254 = d^2 * d^4 * ... * d^128 (0 maps to 0).
  always_comb begin
    sq  = gmul(d_i, d_i);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign q_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module sub_bytes #(
  parameter int NUM_LANES = 16
) (
  input  logic [8*NUM_LANES-1:0] d_i,
  output logic [8*NUM_LANES-1:0] q_o
);
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    aes_sbox u_sbox (.d_i(d_i[8*g +: 8]), .q_o(q_o[8*g +: 8]));
  end
endmodule

module aes_enc_iter #(
  parameter int NROUNDS = 10,
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);
  if (NROUNDS != 10) begin : g_cfg_err
    $error("aes_enc_iter: only NROUNDS=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d, rkey_q, rkey_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         abort_w;

`ifdef AES_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the FIPS-197 stream sits at bits [8*(15-n) +: 8]; state is column-major.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  logic [127:0] sb, sr, mc, rk_nxt, round_out;
  logic [31:0]  rot_w3, sub_w, w4, w5, w6, w7;
  logic         last;

  sub_bytes #(.NUM_LANES(16)) u_sb_state (.d_i(state_q), .q_o(sb));

  assign rot_w3 = {rkey_q[23:0], rkey_q[31:24]};
  sub_bytes #(.NUM_LANES(4)) u_sb_key (.d_i(rot_w3), .q_o(sub_w));

  assign w4     = rkey_q[127:96] ^ sub_w ^ {rcon_q, 24'h0};
  assign w5     = rkey_q[95:64] ^ w4;
  assign w6     = rkey_q[63:32] ^ w5;
  assign w7     = rkey_q[31:0] ^ w6;
  assign rk_nxt = {w4, w5, w6, w7};

  assign sr = shift_rows(sb);
  assign mc = {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])};
  assign last      = (rnd_q == 4'(NROUNDS));
  assign round_out = (last ? sr : mc) ^ rk_nxt;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    if (abort_w && fsm_q != IDLE) begin
      fsm_d   = IDLE;
      state_d = '0;
      rkey_d  = '0;
      rnd_d   = '0;
      rcon_d  = '0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          fsm_d   = BUSY;
          state_d = plaintext ^ key;
          rkey_d  = key;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
        end
        BUSY: begin
          state_d = round_out;
          rkey_d  = rk_nxt;
          rnd_d   = rnd_q + 4'd1;
          rcon_d  = xt(rcon_q);
          if (last) fsm_d = DONE;
        end
        DONE: if (out_ready) begin
          fsm_d = IDLE;
          if (ZEROIZE) begin
            state_d = '0;
            rkey_d  = '0;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign ciphertext = out_valid ? state_q : '0;
endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors, latency, back-pressure, back-to-back, reset, abort.
module tb_aes_enc_iter;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RB0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] RB1 = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [127:0] plaintext = '0, key = '0, ciphertext;
`ifdef AES_ABORT_EN
  logic         abort = 1'b0;
`endif
  int           checks = 0, errors = 0, cyc = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_enc_iter dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .plaintext(plaintext), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every output handshake pops one expected ciphertext.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {127'b0, out_valid}, 128'd0);
      else chk("ciphertext", ciphertext, exp_q.pop_front());
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                      output int acc_cyc);
    int n = 0;
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("accept_timeout", {127'b0, in_ready}, 128'd1);
    tick();
    exp_q.push_back(ct);
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(output int c);
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("out_valid_timeout", {127'b0, out_valid}, 128'd1);
    c = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin tick(); n++; end
    chk("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int t0, t1;
    #12;
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_ciphertext", ciphertext, 128'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 with latency measurement
    send(P1, K1, C1, t0);
    in_valid = 1'b0;
    chk("ct_zero_busy", ciphertext, 128'd0);
    chk("in_ready_busy", {127'b0, in_ready}, 128'd0);
    wait_valid(t1);
    chk("c1_latency", 128'(t1 - t0), 128'd10);
    drain();
    chk("zeroize_state", dut.state_q, 128'd0);
    chk("zeroize_rkey", dut.rkey_q, 128'd0);

    // FIPS-197 App.B with round states
    send(PB, KB, CB, t0);
    in_valid = 1'b0;
    chk("appb_round0", dut.state_q, RB0);
    tick();
    chk("appb_round1", dut.state_q, RB1);
    drain();

    // Back-pressure: junk offered on in_valid must be ignored
    out_ready = 1'b0;
    send(PB, KB, CB, t0);
    plaintext = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    key       = 128'h0;
    wait_valid(t1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_ct_stable", ciphertext, CB);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("bp_no_extra", {127'b0, out_valid}, 128'd0);
    end

    // Back-to-back with in_valid held high
    send(P1, K1, C1, t0);
    send(PB, KB, CB, t1);
    in_valid = 1'b0;
    chk("b2b_spacing", 128'(t1 - t0), 128'd12);
    drain();

    // Reset asserted mid-block
    send(P1, K1, C1, t0);
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("midrst_ct", ciphertext, 128'd0);
    chk("midrst_state", dut.state_q, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(P1, K1, C1, t0);
    in_valid = 1'b0;
    drain();

`ifdef AES_ABORT_EN
    send(P1, K1, C1, t0);
    in_valid = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    chk("abort_out_valid", {127'b0, out_valid}, 128'd0);
    chk("abort_state", dut.state_q, 128'd0);
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_output", {127'b0, out_valid}, 128'd0);
    end
    send(PB, KB, CB, t0);
    in_valid = 1'b0;
    drain();
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
